// File: rtl/input_arguments_pkg.sv
// Shared definitions for the plusarg string parser.
// Holds the parser state encoding, the ASCII bytes the parser reacts to,
// the two recognised keys packed four bytes per word (first byte in the
// most significant position), and a delimiter test used by the FSM.
package input_arguments_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEY      = 3'd1,
    ST_VAL_MODE = 3'd2,
    ST_VAL_FILE = 3'd3,
    ST_SKIP     = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [7:0] CH_PLUS  = 8'h2B;  // '+'
  localparam logic [7:0] CH_EQUAL = 8'h3D;  // '='
  localparam logic [7:0] CH_NUL   = 8'h00;  // string terminator
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // Keys as they appear in the key buffer after four shifted-in bytes.
  localparam logic [31:0] KEY_MODE = 32'h4D4F4445;  // "MODE"
  localparam logic [31:0] KEY_FILE = 32'h46494C45;  // "FILE"

  function automatic logic is_delim(input logic [7:0] c);
    return (c == CH_SPACE) || (c == CH_TAB) || (c == CH_LF);
  endfunction

endpackage

// File: rtl/input_arguments_ascii_hex_digit.sv
// ascii_hex_digit: purely combinational classifier for one ASCII byte.
// Ports:
//   code   in  8  ASCII byte
//   is_dec out 1  byte is '0'-'9'
//   is_hex out 1  byte is '0'-'9', 'a'-'f' or 'A'-'F'
//   value  out 4  digit value (0 when the byte is not a hex digit)
module ascii_hex_digit (
  input  logic [7:0] code,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] value
);

  always_comb begin
    is_dec = 1'b0;
    is_hex = 1'b0;
    value  = 4'd0;
    if (code >= 8'h30 && code <= 8'h39) begin
      is_dec = 1'b1;
      is_hex = 1'b1;
      value  = code[3:0];
    end else if ((code >= 8'h61 && code <= 8'h66) ||
                 (code >= 8'h41 && code <= 8'h46)) begin
      // 'a'/'A' have low nibble 1, so adding 9 yields 10..15.
      is_hex = 1'b1;
      value  = code[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/input_arguments.sv
// input_arguments: parses a NUL-terminated plusarg string of the form
// "+MODE=<dec> +FILE=<hex>" delivered one byte per cycle, and presents
// the resulting trace-file handle and run mode.
// Ports:
//   clk        in   1             clock, rising edge
//   rst        in   1             asynchronous active-high reset
//   char_valid in   1             byte present on char_data
//   char_data  in   8             ASCII byte of the argument string
//   char_ready out  1             byte accepted when char_valid && char_ready
//   file       out  HANDLE_WIDTH  trace-file handle, 0 = none
//   mode       out  MODE_WIDTH    run mode
//   done       out  1             string fully parsed, outputs final
//   err        out  1             parse error or FILE missing
module input_arguments
  import input_arguments_pkg::*;
#(
  parameter int HANDLE_WIDTH = 32,
  parameter int MODE_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    char_valid,
  input  logic [7:0]              char_data,
  output logic                    char_ready,
  output logic [HANDLE_WIDTH-1:0] file,
  output logic [MODE_WIDTH-1:0]   mode,
  output logic                    done,
  output logic                    err
);

  localparam int HEX_DIGITS = HANDLE_WIDTH / 4;
  localparam int CNT_W      = $clog2(HEX_DIGITS + 1);

  state_t                  state_reg, state_next;
  logic [31:0]             key_reg, key_next;
  logic [2:0]              key_count_reg, key_count_next;
  logic [MODE_WIDTH-1:0]   mode_acc_reg, mode_acc_next;
  logic [HANDLE_WIDTH-1:0] handle_acc_reg, handle_acc_next;
  logic [CNT_W-1:0]        hex_count_reg, hex_count_next;
  logic [HANDLE_WIDTH-1:0] file_reg, file_next;
  logic [MODE_WIDTH-1:0]   mode_reg, mode_next;
  logic                    err_reg, err_next;
  logic                    done_reg, done_next;

  logic       digit_is_dec;
  logic       digit_is_hex;
  logic [3:0] digit_value;
  logic       accept;

  ascii_hex_digit u_digit (
    .code   (char_data),
    .is_dec (digit_is_dec),
    .is_hex (digit_is_hex),
    .value  (digit_value)
  );

  // Ready is held low while reset is applied as well as once parsing is done.
  assign char_ready = !rst && (state_reg != ST_DONE);
  assign accept     = char_valid && char_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      key_reg        <= '0;
      key_count_reg  <= '0;
      mode_acc_reg   <= '0;
      handle_acc_reg <= '0;
      hex_count_reg  <= '0;
      file_reg       <= '0;
      mode_reg       <= '0;
      err_reg        <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      key_reg        <= key_next;
      key_count_reg  <= key_count_next;
      mode_acc_reg   <= mode_acc_next;
      handle_acc_reg <= handle_acc_next;
      hex_count_reg  <= hex_count_next;
      file_reg       <= file_next;
      mode_reg       <= mode_next;
      err_reg        <= err_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    key_next        = key_reg;
    key_count_next  = key_count_reg;
    mode_acc_next   = mode_acc_reg;
    handle_acc_next = handle_acc_reg;
    hex_count_next  = hex_count_reg;
    file_next       = file_reg;
    mode_next       = mode_reg;
    err_next        = err_reg;
    done_next       = done_reg;

    if (accept) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (char_data == CH_PLUS) begin
            state_next     = ST_KEY;
            key_next       = '0;
            key_count_next = '0;
          end else if (char_data == CH_NUL) begin
            state_next = ST_DONE;
          end else if (!is_delim(char_data)) begin
            state_next = ST_SKIP;
            err_next   = 1'b1;
          end
        end

        ST_KEY: begin
          if (char_data == CH_EQUAL) begin
            if (key_count_reg == 3'd4 && key_reg == KEY_MODE) begin
              state_next    = ST_VAL_MODE;
              mode_acc_next = '0;
            end else if (key_count_reg == 3'd4 && key_reg == KEY_FILE) begin
              state_next      = ST_VAL_FILE;
              handle_acc_next = '0;
              hex_count_next  = '0;
            end else begin
              state_next = ST_SKIP;
            end
          end else if (char_data == CH_NUL) begin
            state_next = ST_DONE;
          end else if (is_delim(char_data)) begin
            // The delimiter itself ends the discarded token, which is
            // exactly what SKIP would do with it.
            state_next = ST_IDLE;
          end else if (key_count_reg == 3'd4) begin
            state_next = ST_SKIP;
          end else begin
            key_next       = {key_reg[23:0], char_data};
            key_count_next = key_count_reg + 3'd1;
          end
        end

        ST_VAL_MODE: begin
          if (digit_is_dec) begin
            // acc*10 as (acc<<3)+(acc<<1), wrapping at MODE_WIDTH bits.
            mode_acc_next = (mode_acc_reg << 3) + (mode_acc_reg << 1)
                          + MODE_WIDTH'(digit_value);
          end else if (is_delim(char_data)) begin
            mode_next  = mode_acc_reg;
            state_next = ST_IDLE;
          end else if (char_data == CH_NUL) begin
            mode_next  = mode_acc_reg;
            state_next = ST_DONE;
          end else begin
            err_next   = 1'b1;
            state_next = ST_SKIP;
          end
        end

        ST_VAL_FILE: begin
          if (digit_is_hex) begin
            if (hex_count_reg == CNT_W'(HEX_DIGITS)) begin
              err_next   = 1'b1;
              state_next = ST_SKIP;
            end else begin
              handle_acc_next = {handle_acc_reg[HANDLE_WIDTH-5:0], digit_value};
              hex_count_next  = hex_count_reg + 1'b1;
            end
          end else if (is_delim(char_data)) begin
            file_next  = handle_acc_reg;
            state_next = ST_IDLE;
          end else if (char_data == CH_NUL) begin
            file_next  = handle_acc_reg;
            state_next = ST_DONE;
          end else begin
            err_next   = 1'b1;
            state_next = ST_SKIP;
          end
        end

        ST_SKIP: begin
          if (char_data == CH_NUL) begin
            state_next = ST_DONE;
          end else if (is_delim(char_data)) begin
            state_next = ST_IDLE;
          end
        end

        ST_DONE: begin
          state_next = ST_DONE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase

      // Entering DONE: flag a missing handle, looking at the value being
      // committed on this same byte so a trailing "+FILE=x\0" counts.
      if (state_next == ST_DONE && state_reg != ST_DONE) begin
        done_next = 1'b1;
        if (file_next == '0) begin
          err_next = 1'b1;
        end
      end
    end
  end

  assign file = file_reg;
  assign mode = mode_reg;
  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_input_arguments.sv
module tb_input_arguments;

  logic        clk;
  logic        rst;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [31:0] file;
  logic [31:0] mode;
  logic        done;
  logic        err;

  int checks;
  int failures;

  input_arguments #(
    .HANDLE_WIDTH (32),
    .MODE_WIDTH   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .file       (file),
    .mode       (mode),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Drives one byte for one clock; returns at posedge+1 with outputs settled.
  task automatic send_byte(input logic [7:0] b);
    char_valid = 1'b1;
    char_data  = b;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_final(input string tag, input logic [31:0] f,
                             input logic [31:0] m, input logic e);
    check({tag, ".done"}, done, 1);
    check({tag, ".file"}, file, f);
    check({tag, ".mode"}, mode, m);
    check({tag, ".err"},  err,  e);
    check({tag, ".ready"}, char_ready, 0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;

    // Reset state while rst is held.
    #12;
    check("rst.ready", char_ready, 0);
    check("rst.file",  file, 0);
    check("rst.mode",  mode, 0);
    check("rst.done",  done, 0);
    check("rst.err",   err,  0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle.ready", char_ready, 1);

    // Basic string, with commit latency observed around the delimiter.
    send_str("+FILE=3");
    check("t1.file_pending", file, 0);
    send_str(" ");
    check("t1.file_commit", file, 32'h3);
    send_str("+MODE=1");
    check("t1.done_before_nul", done, 0);
    send_byte(8'h00);
    check_final("t1", 32'h3, 32'd1, 1'b0);

    // FILE missing.
    do_reset();
    send_str("+MODE=1");
    send_byte(8'h00);
    check_final("t2", 32'h0, 32'd1, 1'b1);

    // Full-width handle and an unknown key that must be ignored.
    do_reset();
    send_str("+FILE=80000003 +DEBUG=7 +MODE=0");
    send_byte(8'h00);
    check_final("t3", 32'h80000003, 32'd0, 1'b0);

    // Nine hex digits overflow the handle.
    do_reset();
    send_str("+FILE=123456789");
    send_byte(8'h00);
    check_final("t4", 32'h0, 32'd0, 1'b1);

    // Repeated key, last wins; bytes after done are refused.
    do_reset();
    send_str("+FILE=A +MODE=1 ");
    check("t5.mode_first", mode, 32'd1);
    send_str("+MODE=0");
    send_byte(8'h00);
    check_final("t5", 32'hA, 32'd0, 1'b0);
    send_str("+MODE=5 +FILE=9 ");
    send_byte(8'h00);
    check("t5.post.file", file, 32'hA);
    check("t5.post.mode", mode, 32'd0);
    check("t5.post.err",  err,  0);
    check("t5.post.done", done, 1);

    // Asynchronous reset in the middle of a value.
    do_reset();
    send_str("+FILE=1");
    #2 rst = 1'b1;
    #1;
    check("t6.rst.file",  file, 0);
    check("t6.rst.ready", char_ready, 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("t6.after.file", file, 0);
    check("t6.after.done", done, 0);
    send_str("+FILE=2");
    send_byte(8'h00);
    check_final("t6", 32'h2, 32'd0, 1'b0);

    // Multi-digit decimal, mixed-case hex, tab and newline delimiters.
    do_reset();
    send_str("+MODE=305\t+FILE=fF\n");
    send_byte(8'h00);
    check_final("t7", 32'hFF, 32'd305, 1'b0);

    // Bad character in a decimal value: err set, value not committed.
    do_reset();
    send_str("+FILE=5 +MODE=12x");
    send_byte(8'h00);
    check_final("t8", 32'h5, 32'd0, 1'b1);

    // Stray byte outside a token sets err; empty FILE value commits 0.
    do_reset();
    send_str("+FILE=7 x +MODE=4");
    send_byte(8'h00);
    check_final("t9", 32'h7, 32'd4, 1'b1);
    do_reset();
    send_str("+FILE=7 +FILE=");
    send_byte(8'h00);
    check_final("t10", 32'h0, 32'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
